// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the registered logic unit.
// Operand A chaining is enabled by defining LU_CHAIN_EN.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOT_A  = 3'd2,
    OP_XOR    = 3'd3,
    OP_XNOR   = 3'd4,
    OP_NAND   = 3'd5,
    OP_NOR    = 3'd6,
    OP_PASS_B = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Input and output channels of logic_unit_pipe.
// in_chain exists only when LU_CHAIN_EN is defined.
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
`ifdef LU_CHAIN_EN
  logic             in_chain;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_op,
`ifdef LU_CHAIN_EN
    output in_chain,
`endif
    output out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_parity, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op,
`ifdef LU_CHAIN_EN
    input  in_chain,
`endif
    input  out_ready,
    output in_ready, out_valid, out_y, out_zero, out_parity, op_count
  );

endinterface

// File: rtl/logic_unit_alu.sv
// Combinational eight-function bitwise unit; no state, no carries.
module logic_unit_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_NOT_A:  y = ~a;
      OP_XOR:    y = a ^ b;
      OP_XNOR:   y = ~(a ^ b);
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_PASS_B: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with one back-pressurable output stage, flags and a
// handshake counter. Define LU_CHAIN_EN to allow operand A to come from out_y.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  logic_unit_pipe_if.slave bus
);

  logic             valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             parity_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] alu_y;

  // The output register frees up in the same cycle its result is consumed.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = valid_q && bus.out_ready;

`ifdef LU_CHAIN_EN
  // Chaining reads the result register whether or not it has been consumed.
  assign op_a = bus.in_chain ? y_q : bus.in_a;
`else
  assign op_a = bus.in_a;
`endif

  logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (op_a),
    .b  (bus.in_b),
    .op (bus.in_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        valid_q  <= 1'b1;
        y_q      <= alu_y;
        zero_q   <= (alu_y == '0);
        parity_q <= ^alu_y;
      end else if (deliver) begin
        valid_q  <= 1'b0;
      end
      if (deliver) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_y      = y_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_parity = parity_q;
  assign bus.op_count   = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe; chaining steps run when LU_CHAIN_EN is defined.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_count = 0;
  logic [15:0] exp_count = '0;
  logic [7:0]  model_y = '0;
  logic [7:0]  sb[$];

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a ^ b;
      3'd4:    return ~(a ^ b);
      3'd5:    return ~(a & b);
      3'd6:    return ~(a | b);
      default: return b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic chain, output int waits);
    logic use_chain;
    logic [7:0] y;
    bit got;
    use_chain = 1'b0;
    got = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
`ifdef LU_CHAIN_EN
    bus.in_chain = chain;
    use_chain = chain;
`endif
    for (waits = 0; waits < 50; waits++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      y = ref_alu(use_chain ? model_y : a, b, op);
      sb.push_back(y);
      model_y = y;
    end else begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef LU_CHAIN_EN
    bus.in_chain = 1'b0;
`endif
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    sb.delete();
    exp_count = '0;
    model_y = '0;
  endtask

  // Output-side monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
      checkOutput("op_count", {16'd0, bus.op_count}, {16'd0, exp_count});
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("[TB] FAIL unexpected_output: got %0h expected no result", bus.out_y);
        end
        if (sb.size() != 0) begin
          logic [7:0] e;
          e = sb.pop_front();
          checkOutput("sb_y", {24'd0, bus.out_y}, {24'd0, e});
          checkOutput("sb_zero", {31'd0, bus.out_zero}, {31'd0, (e == 8'h00)});
          checkOutput("sb_parity", {31'd0, bus.out_parity}, {31'd0, ^e});
        end
        exp_count++;
        hs_count++;
      end
    end
  end

  initial begin
    logic [7:0] sweep_tbl [8];
    int w;
    int hs0;
    logic [15:0] c0;
    sweep_tbl = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h0F};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_a = 8'h3C; bus4.in_b = 8'h0F; bus4.in_op = 3'd1;
    bus4.out_ready = 1'b1;
`ifdef LU_CHAIN_EN
    bus.in_chain = 1'b0;
    bus4.in_chain = 1'b0;
`endif
    nextCycle();
    doReset();

    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_y", {24'd0, bus.out_y}, 32'd0);
    checkOutput("rst_out_zero", {31'd0, bus.out_zero}, 32'd1);
    checkOutput("rst_out_parity", {31'd0, bus.out_parity}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    nextCycle();

    $display("[TB] basic AND");
    applyStimulus(8'hF0, 8'h3C, OP_AND, 1'b0, w);
    @(negedge clk);
    checkOutput("and_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("and_y", {24'd0, bus.out_y}, 32'h30);
    checkOutput("and_zero", {31'd0, bus.out_zero}, 32'd0);
    checkOutput("and_parity", {31'd0, bus.out_parity}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("and_count", {16'd0, bus.op_count}, 32'd1);
    nextCycle();

    $display("[TB] opcode sweep");
    for (int op = 0; op < 8; op++) begin
      applyStimulus(8'hA5, 8'h0F, op[2:0], 1'b0, w);
      @(negedge clk);
      checkOutput("sweep_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("sweep_y", {24'd0, bus.out_y}, {24'd0, sweep_tbl[op]});
      nextCycle();
    end

    $display("[TB] back-pressure");
    nextCycle();
    bus.out_ready = 1'b0;
    applyStimulus(8'hFF, 8'hFF, OP_XOR, 1'b0, w);
    bus.in_valid = 1'b1; bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_op = OP_OR;
    hs0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stall_y", {24'd0, bus.out_y}, 32'h00);
      checkOutput("stall_zero", {31'd0, bus.out_zero}, 32'd1);
      checkOutput("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      nextCycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("release_one_result", hs_count - hs0, 32'd1);
    checkOutput("release_valid_clear", {31'd0, bus.out_valid}, 32'd0);
    nextCycle();

    $display("[TB] throughput");
    hs0 = hs_count;
    c0 = bus.op_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'(i * 17), 8'h0F, OP_XOR, 1'b0, w);
      checkOutput("b2b_no_wait", w, 32'd0);
    end
    nextCycle();
    nextCycle();
    checkOutput("b2b_handshakes", hs_count - hs0, 32'd4);
    checkOutput("b2b_count_delta", {16'd0, bus.op_count - c0}, 32'd4);

    $display("[TB] counter wrap, CNT_W=4");
    bus4.in_valid = 1'b1;
    repeat (17) nextCycle();
    bus4.in_valid = 1'b0;
    repeat (3) nextCycle();
    checkOutput("wrap_count", {28'd0, bus4.op_count}, 32'd1);
    checkOutput("wrap_valid", {31'd0, bus4.out_valid}, 32'd0);

    $display("[TB] reset mid-stall");
    bus.out_ready = 1'b0;
    applyStimulus(8'h0F, 8'h01, OP_OR, 1'b0, w);
    @(negedge clk);
    checkOutput("prestall_valid", {31'd0, bus.out_valid}, 32'd1);
    nextCycle();
    doReset();
    @(negedge clk);
    checkOutput("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_y", {24'd0, bus.out_y}, 32'd0);
    checkOutput("midrst_zero", {31'd0, bus.out_zero}, 32'd1);
    checkOutput("midrst_count", {16'd0, bus.op_count}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    nextCycle();
    bus.out_ready = 1'b1;

`ifdef LU_CHAIN_EN
    $display("[TB] chaining");
    applyStimulus(8'h01, 8'h02, OP_OR, 1'b0, w);
    applyStimulus(8'h00, 8'hFF, OP_XOR, 1'b1, w);
    @(negedge clk);
    checkOutput("chain_y", {24'd0, bus.out_y}, 32'hFC);
    nextCycle();
    doReset();
    applyStimulus(8'h55, 8'h10, OP_OR, 1'b1, w);
    @(negedge clk);
    checkOutput("chain_after_rst_y", {24'd0, bus.out_y}, 32'h10);
    nextCycle();
`endif

    nextCycle();
    nextCycle();
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered successor to the team's two-input gate block. Takes two WIDTH-bit operands and a 3-bit opcode over a valid/ready input channel. Computes one of eight bitwise functions and returns the result through a single registered, back-pressurable output stage, with status flags and a transfer counter. Sits between a stimulus/decoder stage and any downstream consumer that can stall.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 16, width of the completed-transfer counter op_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream presents operands and opcode
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  3  function select
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  downstream accepts the result
out_y  out  WIDTH  registered result
out_zero  out  1  registered: out_y == 0
out_parity  out  1  registered: XOR-reduce of out_y
op_count  out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst, sampled only on the clk rising edge.
- Reset values: out_valid=0, out_y=0, out_zero=1, out_parity=0, op_count=0. in_ready=1 after reset, since it is combinational from out_valid.
- Opcodes: 0 AND, 1 OR, 2 NOT_A (~in_b ignored), 3 XOR, 4 XNOR, 5 NAND, 6 NOR, 7 PASS_B. All bitwise over WIDTH bits; no carries, no truncation.
- Handshake: in_ready = !out_valid || out_ready. This is a combinational path out_ready->in_ready, with no path from in_valid.
- Accept when in_valid && in_ready. On the next edge, out_y, out_zero and out_parity load the new result and out_valid is set to 1. Latency is 1 cycle.
- Output handshake is out_valid && out_ready. If no accept happens in the same cycle, out_valid clears next edge.
- Simultaneous output handshake and input accept: out_valid stays 1 and the new result loads. This gives full throughput of 1 result per cycle.
- Stall (out_valid && !out_ready): out_y, flags and out_valid hold stable. in_ready=0, and input signals are ignored.
- op_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- in_valid without in_ready: no state change. Upstream must hold its data.
- rst asserted mid-stall: the pending result is discarded and all outputs return to reset values on that edge. rst has priority over any handshake in the same cycle.

Optional Feature:
LU_CHAIN_EN
- Defined: adds input port in_chain (1 bit). On an accept with in_chain=1, operand A is taken from the current out_y register instead of in_a. This applies whether or not out_y has been consumed, and immediately after reset it uses 0. Allows chained operations without re-sending results.
- Undefined: the port is absent and operand A is always in_a.

Decomposition:
- Package logic_unit_pkg: opcode enum/localparams (OP_AND=3'd0 … OP_PASS_B=3'd7) and OP_W=3.
- One natural sub-module, logic_unit_alu: purely combinational. Takes (a, b, op) and produces y. The parent holds the handshake register, flags, counter and chain mux.

Test Plan:
- WIDTH=8, op=AND, a=0xF0, b=0x3C, out_ready=1 -> next cycle out_valid=1, out_y=0x30, out_zero=0, out_parity=0; op_count=1 after the handshake.
- Sweep op 0..7 with a=0xA5, b=0x0F -> out_y = 0x05, 0xAF, 0x5A, 0xAA, 0x55, 0xFA, 0x50, 0x0F respectively, each 1 cycle after accept.
- Back-pressure: accept a=0xFF, b=0xFF, XOR; hold out_ready=0 for 3 cycles -> out_y=0x00, out_zero=1 held stable, in_ready=0 throughout; new input during the stall is not taken; releasing out_ready delivers exactly one result.
- Throughput: 4 back-to-back inputs with out_ready=1 -> 4 consecutive out_valid cycles in order, op_count=4. With CNT_W=4, 17 handshakes -> op_count=1.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, out_y=0, out_zero=1, op_count=0, in_ready=1.
- LU_CHAIN_EN: accept OR a=0x01,b=0x02 (y=0x03), then in_chain=1, XOR b=0xFF -> out_y=0xFC. First accept after reset with in_chain=1, OR b=0x10 -> out_y=0x10.
